uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte queue directly upstream of uart_trans.
- Accepts bytes from a producer via a write strobe, buffers up to DEPTH entries, and presents the head byte plus a valid flag to the transmitter's data input.
- Advances on the transmitter's per-frame load pulse, so back-to-back frames no longer rely on bench-side waits.
- Reports occupancy and sticky overflow/underrun errors.

Parameters:
- DEPTH, 8, number of byte entries; power of two, minimum 2.
- DATA_W, 8, width of one queued word; matches the uart_trans data width.

Ports:
- clk  input  1  system clock; the same clock as the downstream uart_trans.
- rst  input  1  reset, asynchronous, active-high.
- wr_en  input  1  producer write strobe; one word per cycle while high.
- wr_data  input  DATA_W  word written when wr_en is high.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  $clog2(DEPTH)+1  number of stored words, including the head.
- tx_data  output  DATA_W  head word; drives uart_trans data.
- tx_valid  output  1  tx_data holds an unsent word.
- tx_load  input  1  one-cycle pulse from the transmitter when it latches data at frame start; pops the head.
- overflow  output  1  sticky; a write was dropped because the queue was full.
- underrun  output  1  sticky; tx_load arrived while tx_valid was low.
- err_clr  input  1  synchronous clear of overflow and underrun.

Behaviour:
- Reset (async assert, takes effect immediately): pointers=0, count=0, empty=1, full=0, tx_valid=0, tx_data=0, overflow=0, underrun=0. Memory contents are don't-care.
- Storage: circular buffer with wr_ptr and rd_ptr of width $clog2(DEPTH). Both pointers wrap modulo DEPTH with no gap; all DEPTH slots are usable.
- tx_data and tx_valid are registered, giving show-ahead (first-word-fall-through) output. Head register FSM has two states:
  - HOLD_EMPTY: tx_valid=0.
    - On an accepted write, the next cycle moves to HOLD_VALID with tx_data=wr_data (1-cycle latency from wr_en to tx_valid).
  - HOLD_VALID: tx_valid=1.
    - tx_load pops the head.
    - If count>1 after the pop, the next stored word loads into tx_data the following cycle and tx_valid stays 1 with no bubble.
    - If count==1, the FSM moves to HOLD_EMPTY; tx_data keeps its last value.
- Write acceptance: accepted = wr_en && (!full || pop_this_cycle), where pop = tx_load && tx_valid.
  - A write and a pop in the same cycle while full: both happen and count is unchanged.
  - A write and a pop in the same cycle with count==1: the new word becomes head next cycle and tx_valid stays 1.
- Count update: count_next = count + accepted - pop. count never exceeds DEPTH and never goes below 0.
- Rejected write (wr_en && full && !pop): data is dropped, pointers are unchanged, overflow is set on the next edge.
- Underrun: tx_load while !tx_valid is ignored for the data path and sets underrun on the next edge.
- Error clear: err_clr clears both flags. If err_clr and a new error occur in the same cycle, set wins.
- full and empty are combinational from count.
- Reset mid-operation: all queued words are discarded. tx_valid drops asynchronously. The transmitter then sees tx_data=0.
- A tx_load pulse that lasts longer than one cycle pops once per high cycle. The transmitter guarantees single-cycle pulses.

Decomposition:
- uart_pkg: DATA_W default constant, a function returning the count width for DEPTH, and the head FSM state enum {HOLD_EMPTY, HOLD_VALID}. The package is shared with uart_trans and uart_rcv.
- One sub-module, uart_fifo_mem: DEPTH x DATA_W storage with a synchronous write port and a combinational read port. Pointer and count logic, the FSM, and the error flags stay in uart_tx_queue.

Test Plan (DEPTH=4):
- Reset, then write 0xA5 one cycle -> next cycle tx_valid=1, tx_data=0xA5, count=1, empty=0.
- Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> full=1 and count=4. A fifth write of 0x55 -> overflow=1, count stays 4. Pops then yield 0x11, 0x22, 0x33, 0x44, never 0x55.
- While full, wr_en=1 with 0x66 and tx_load=1 in the same cycle -> count stays 4, overflow stays 0. Draining yields 0x22, 0x33, 0x44, 0x66.
- Fill 4 words, then pulse tx_load every cycle -> tx_valid stays 1 with no bubble. tx_data steps through the words, then tx_valid=0 and empty=1 one cycle after the last pop.
- With the queue empty, pulse tx_load -> underrun=1. err_clr -> 0 next cycle. err_clr together with another tx_load -> underrun stays 1.
- Loaded with 3 words, assert rst mid-cycle -> tx_valid=0 and count=0 immediately. After release, writing 0x7E returns 0x7E first, with no stale words.
- Wrap check: more than 8 write/pop pairs with random bytes -> output order equals input order across the pointer wrap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width, queue count width helper and head-register states.
package uart_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_VALID = 1'b1
    } headState_t;

    // Occupancy needs one extra bit so that a completely full queue (DEPTH) is representable.
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write port, combinational read port, no reset.
module uart_fifo_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [DATA_W-1:0]        wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [DATA_W-1:0]        rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding uart_trans: show-ahead head register, advanced by the transmitter's load pulse.
// Handshake: a word leaves the queue in any cycle where tx_load && tx_valid; tx_load with tx_valid low only flags underrun.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         full,
    output logic                         empty,
    output logic [countWidth(DEPTH)-1:0] count,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         tx_valid,
    input  logic                         tx_load,
    output logic                         overflow,
    output logic                         underrun,
    input  logic                         err_clr,
    output headState_t                   headState
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = countWidth(DEPTH);

    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  nextRdPtr;
    logic [DATA_W-1:0] nextHead;
    logic [CNT_W-1:0]  countNext;
    logic              pop;
    logic              accepted;

    assign pop       = tx_load && tx_valid;
    assign accepted  = wr_en && (!full || pop);
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign nextRdPtr = rdPtr + PTR_W'(1);

    always_comb begin
        countNext = count;
        case ({accepted, pop})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;
        endcase
    end

    // The memory holds every queued word including the head; its read port looks one slot
    // past the head so the successor is ready the moment the head is popped.
    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) u_mem (
        .clk   (clk),
        .wrEn  (accepted),
        .wrAddr(wrPtr),
        .wrData(wr_data),
        .rdAddr(nextRdPtr),
        .rdData(nextHead)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (accepted) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= nextRdPtr;
            end
            count <= countNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headState <= HOLD_EMPTY;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
        end else begin
            case (headState)
                HOLD_EMPTY: begin
                    if (accepted) begin
                        headState <= HOLD_VALID;
                        tx_valid  <= 1'b1;
                        tx_data   <= wr_data;
                    end
                end
                HOLD_VALID: begin
                    if (pop) begin
                        if (count > CNT_W'(1)) begin
                            tx_data <= nextHead;
                        end else if (accepted) begin
                            // Last word leaves while a new one arrives: hand it straight to the head.
                            tx_data <= wr_data;
                        end else begin
                            headState <= HOLD_EMPTY;
                            tx_valid  <= 1'b0;
                        end
                    end
                end
                default: begin
                    headState <= HOLD_EMPTY;
                    tx_valid  <= 1'b0;
                end
            endcase
        end
    end

    // A clear and a fresh error in the same cycle leave the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (err_clr) begin
                overflow <= 1'b0;
                underrun <= 1'b0;
            end
            if (wr_en && full && !pop) begin
                overflow <= 1'b1;
            end
            if (tx_load && !tx_valid) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue at DEPTH=4: directed scenarios plus random traffic against a queue model.
module tb_uart_tx_queue;
    import uart_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = countWidth(DEPTH);

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_load;
    logic              overflow;
    logic              underrun;
    logic              err_clr;
    headState_t        headState;

    uart_tx_queue #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_load  (tx_load),
        .overflow (overflow),
        .underrun (underrun),
        .err_clr  (err_clr),
        .headState(headState)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Scoreboard of words in the order they must leave the queue, plus model occupancy and flags.
    logic [DATA_W-1:0] exp_q[$];
    int                mdlCount = 0;
    bit                mdlOvf   = 1'b0;
    bit                mdlUnd   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: one cycle of stimulus; the model advances with the clock edge.
    task automatic drive(input bit wr, input logic [DATA_W-1:0] d, input bit ld, input bit clr);
        bit doPop;
        bit acc;
        wr_en   = wr;
        wr_data = d;
        tx_load = ld;
        err_clr = clr;
        doPop = ld && (mdlCount > 0);
        acc   = wr && ((mdlCount < DEPTH) || doPop);
        if (acc) exp_q.push_back(d);
        @(posedge clk);
        #1;
        if (clr) begin
            mdlOvf = 1'b0;
            mdlUnd = 1'b0;
        end
        if (wr && !acc) mdlOvf = 1'b1;
        if (ld && mdlCount == 0) mdlUnd = 1'b1;
        mdlCount = mdlCount + int'(acc) - int'(doPop);
        wr_en   = 1'b0;
        tx_load = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic resetMid();
        wr_en   = 1'b0;
        tx_load = 1'b0;
        err_clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midreset tx_valid", 32'(tx_valid), 32'd0);
        check("midreset count", 32'(count), 32'd0);
        check("midreset tx_data", 32'(tx_data), 32'd0);
        check("midreset empty", 32'(empty), 32'd1);
        exp_q.delete();
        mdlCount = 0;
        mdlOvf   = 1'b0;
        mdlUnd   = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: compares status every cycle and pops the scoreboard whenever a word is handed over.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("count", 32'(count), 32'(mdlCount));
            check("full", 32'(full), 32'(mdlCount == DEPTH));
            check("empty", 32'(empty), 32'(mdlCount == 0));
            check("tx_valid", 32'(tx_valid), 32'(mdlCount != 0));
            check("headState", 32'(headState), 32'(mdlCount != 0 ? HOLD_VALID : HOLD_EMPTY));
            check("overflow", 32'(overflow), 32'(mdlOvf));
            check("underrun", 32'(underrun), 32'(mdlUnd));
            if (tx_load === 1'b1 && tx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("pop with nothing expected", 32'd1, 32'd0);
                end else begin
                    check("popped word", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end else if (mdlCount != 0 && exp_q.size() != 0) begin
                check("head word", 32'(tx_data), 32'(exp_q[0]));
            end
        end
    end

    logic [DATA_W-1:0] fillA[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [DATA_W-1:0] fillB[4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        tx_load = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset tx_data", 32'(tx_data), 32'd0);

        // Single write, one-cycle latency to the head
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill, overflow, drain in order
        foreach (fillA[i]) drive(1'b1, fillA[i], 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Write and pop together while full
        foreach (fillA[i]) drive(1'b1, fillA[i], 1'b0, 1'b0);
        drive(1'b1, 8'h66, 1'b1, 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Back-to-back pops with no bubble
        foreach (fillB[i]) drive(1'b1, fillB[i], 1'b0, 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Write and pop together with a single stored word
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 8'h02, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Underrun, clear, and clear colliding with a new underrun
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset with words queued
        drive(1'b1, 8'h31, 1'b0, 1'b0);
        drive(1'b1, 8'h32, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        resetMid();
        drive(1'b1, 8'h7E, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic across many pointer wraps
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 99) < 55), DATA_W'($urandom), ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 5));
        end
        repeat (DEPTH + 1) drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
